vga_cell_renderer: RTL and testbench
====================================

Name: vga_cell_renderer

Overview:
- Pixel stage placed directly downstream of the VGA sync/timing generator, replacing the purely combinational painter.
- Consumes the pixel coordinates and sync signals. Looks up a cell-grid board held in registers and produces 8-bit RGB.
- Outputs the sync signals delayed to stay aligned with the RGB pipeline.
- Game logic updates the board through a shadow copy. The shadow is committed to the displayed copy once per frame, so no tearing occurs.

Parameters:
- COLS, 16, number of grid columns (1..16)
- ROWS, 12, number of grid rows (1..16)
- CELL_LOG2, 5, log2 of cell side in pixels (cell = 32x32)
- X0, 64, left edge of grid in pixels
- Y0, 48, top edge of grid in pixels
- BORDER_RGB, 24'hFFFFFF, grid-line colour
- BG_RGB, 24'h000040, colour outside the grid, inside the active area

Ports:
- clk  in  1  pixel clock (VGA PLL output)
- rst  in  1  asynchronous, active-high reset
- x  in  10  pixel column from the timing generator
- y  in  10  pixel row from the timing generator
- hsync_in  in  1  horizontal sync, active-low
- vsync_in  in  1  vertical sync, active-low
- blank_n_in  in  1  1 = active video
- wr_en  in  1  write request to the shadow board
- wr_col  in  4  target column
- wr_row  in  4  target row
- wr_code  in  2  cell code
- wr_ack  out  1  one-cycle write acknowledge
- frame_commit  out  1  one-cycle pulse when shadow is copied to live
- hsync_out  out  1  hsync delayed by 2 cycles
- vsync_out  out  1  vsync delayed by 2 cycles
- blank_n_out  out  1  blank_n delayed by 2 cycles
- red  out  8  pixel red
- green  out  8  pixel green
- blue  out  8  pixel blue

Behaviour:
- Reset (asynchronous, rst=1):
  - shadow and live boards cleared to code 0.
  - hsync_out=1, vsync_out=1, blank_n_out=0, RGB=0, wr_ack=0, frame_commit=0.
  - Sync pipeline registers reset to inactive values (sync 1, blank_n 0).
  - Edge detector history reset to 1.
- Pipeline, 2-cycle latency for all outputs relative to x/y/sync inputs:
  - Stage 1 registers:
    - dx = x - X0 and dy = y - Y0, 10 bits.
    - in_grid = x>=X0 && x<X0+(COLS<<CELL_LOG2) && y>=Y0 && y<Y0+(ROWS<<CELL_LOG2).
    - col = dx>>CELL_LOG2 and row = dy>>CELL_LOG2.
    - border = low CELL_LOG2 bits of dx or dy equal 0 or all-ones.
    - blank_n, hsync and vsync are also registered.
  - Stage 2 registers RGB:
    - if !blank_n, then 0.
    - else if !in_grid, then BG_RGB.
    - else if border, then BORDER_RGB.
    - else the palette of live[row][col]: 0=000000, 1=FF0000, 2=FFFF00, 3=0000FF.
  - Sync and blank_n are passed through the second stage unchanged.
- Write port:
  - When wr_en=1 and wr_col<COLS and wr_row<ROWS: shadow[wr_row][wr_col] <= wr_code, and wr_ack=1 on the next cycle.
  - Out-of-range writes are dropped and wr_ack stays 0.
  - wr_en may be held high for consecutive cycles; each cycle is one write.
- Commit:
  - A falling edge of vsync_in (previous=1, current=0) copies all of shadow to live in one cycle.
  - frame_commit pulses high for the same cycle the copy takes effect. It is registered, i.e. one cycle after the edge sample.
  - The falling edge occurs during vertical blanking, so no visible pixels change mid-frame.
- Simultaneous write and commit in the same cycle:
  - live receives the pre-write shadow contents.
  - The new write lands in shadow and appears after the next commit.
- Pixels outside 640x480 arrive with blank_n=0 and must render black regardless of grid state.
- Reset asserted mid-frame: outputs go to reset values immediately. Normal output resumes two cycles after rst deasserts.
- Width rules:
  - dx and dy wrap when x<X0; in_grid uses the unsigned compares on x/y, not dx/dy.
  - col and row are truncated to 4 bits.

Test Plan:
- Reset: hold rst=1 with random inputs -> RGB=0, hsync_out=vsync_out=1, blank_n_out=0. Release and drive x=100, y=100, blank_n=1 -> two cycles later RGB=000000 (cell (1,1), code 0, interior pixel).
- Pipeline alignment: toggle hsync_in and blank_n_in at a known cycle -> hsync_out and blank_n_out change exactly 2 cycles later. RGB switches from 0 to BG_RGB (x=10, y=10) on that same cycle.
- Shadow/commit: write col=2, row=3, code=1. Scan pixel (x=64+2*32+10, y=48+3*32+10) -> black before the vsync fall. After the vsync fall, frame_commit pulses once and the same pixel renders FF0000.
- Border and background: pixel x=64, y=60 -> FFFFFF. Pixel x=63, y=60 -> 000040. Pixel x=576, y=60 -> 000040 (right edge exclusive).
- Out-of-range write: wr_col=15, wr_row=12 -> wr_ack=0; the board is unchanged after commit.
- Collision: wr_en on the same cycle as the vsync falling edge, col=0, row=0, code=3 -> cell (0,0) stays black this frame and renders 0000FF after the following commit.

Source files
------------

// File: rtl/vga_cell_renderer.sv
// -----------------------------------------------------------------------------
// vga_cell_renderer
//   Pixel stage that sits right after the VGA sync/timing generator. It paints
//   a COLS x ROWS grid of square cells (side 2**CELL_LOG2 pixels) whose codes
//   live in a register board, draws grid lines and a background, and delays the
//   sync/blank strobes so they stay aligned with the 2-cycle RGB pipeline.
//   Game logic writes a shadow board; a falling edge of vsync_in copies the
//   shadow into the displayed (live) board in one cycle, so a frame never tears.
//
// Ports
//   clk, rst                 pixel clock, asynchronous active-high reset
//   x, y                     pixel coordinates from the timing generator
//   hsync_in, vsync_in       active-low syncs; blank_n_in = 1 in active video
//   wr_en/wr_col/wr_row/     shadow-board write request; wr_ack pulses the
//   wr_code, wr_ack          cycle after an in-range write is taken
//   frame_commit             pulses in the cycle the shadow->live copy lands
//   hsync_out, vsync_out,    sync/blank delayed by 2 cycles
//   blank_n_out
//   red, green, blue         8-bit colour, 2 cycles after x/y
// -----------------------------------------------------------------------------
module vga_cell_renderer #(
    parameter int          COLS       = 16,
    parameter int          ROWS       = 12,
    parameter int          CELL_LOG2  = 5,
    parameter int          X0         = 64,
    parameter int          Y0         = 48,
    parameter logic [23:0] BORDER_RGB = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB     = 24'h000040
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       blank_n_in,
    input  logic       wr_en,
    input  logic [3:0] wr_col,
    input  logic [3:0] wr_row,
    input  logic [1:0] wr_code,
    output logic       wr_ack,
    output logic       frame_commit,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       blank_n_out,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue
);

    // Grid bounds held at 11 bits so the right/bottom edge cannot wrap.
    localparam logic [10:0] X_LO = 11'(X0);
    localparam logic [10:0] X_HI = 11'(X0 + (COLS << CELL_LOG2));
    localparam logic [10:0] Y_LO = 11'(Y0);
    localparam logic [10:0] Y_HI = 11'(Y0 + (ROWS << CELL_LOG2));
    localparam logic [9:0]  X0_W = 10'(X0);
    localparam logic [9:0]  Y0_W = 10'(Y0);

    // Boards: one 2-bit code per cell.
    logic [1:0] r_shadow [0:ROWS-1][0:COLS-1];
    logic [1:0] r_live   [0:ROWS-1][0:COLS-1];

    logic       r_vsync_prev;
    logic       r_wr_ack;
    logic       r_frame_commit;

    // Stage 1 registers
    logic [3:0] r_s1_col;
    logic [3:0] r_s1_row;
    logic       r_s1_in_grid;
    logic       r_s1_border;
    logic       r_s1_blank_n;
    logic       r_s1_hsync;
    logic       r_s1_vsync;

    // Stage 2 registers
    logic [23:0] r_rgb;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_blank_n;

    logic [9:0]           w_dx;
    logic [9:0]           w_dy;
    logic [CELL_LOG2-1:0] w_dx_low;
    logic [CELL_LOG2-1:0] w_dy_low;
    logic                 w_in_grid;
    logic                 w_border;
    logic                 w_wr_ok;
    logic                 w_vs_fall;
    logic [1:0]           w_cell_code;
    logic [23:0]          w_cell_rgb;
    logic [23:0]          w_pixel_rgb;

    // -------------------------------------------------------------------------
    // Stage 1 geometry. dx/dy wrap left of / above the grid; in_grid therefore
    // compares the raw coordinates, never dx/dy.
    // -------------------------------------------------------------------------
    always_comb begin
        w_dx      = x - X0_W;
        w_dy      = y - Y0_W;
        w_dx_low  = w_dx[CELL_LOG2-1:0];
        w_dy_low  = w_dy[CELL_LOG2-1:0];
        w_in_grid = ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI) &&
                    ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);
        w_border  = (w_dx_low == '0) || (w_dx_low == '1) ||
                    (w_dy_low == '0) || (w_dy_low == '1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_col     <= '0;
            r_s1_row     <= '0;
            r_s1_in_grid <= 1'b0;
            r_s1_border  <= 1'b0;
            r_s1_blank_n <= 1'b0;
            r_s1_hsync   <= 1'b1;
            r_s1_vsync   <= 1'b1;
        end else begin
            r_s1_col     <= 4'(w_dx >> CELL_LOG2);
            r_s1_row     <= 4'(w_dy >> CELL_LOG2);
            r_s1_in_grid <= w_in_grid;
            r_s1_border  <= w_border;
            r_s1_blank_n <= blank_n_in;
            r_s1_hsync   <= hsync_in;
            r_s1_vsync   <= vsync_in;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2 colour. The cell index is only meaningful inside the grid, so the
    // board is not consulted elsewhere.
    // -------------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_cell_code = 2'b00;
        if (r_s1_in_grid) begin
            w_cell_code = r_live[r_s1_row][r_s1_col];
        end

        w_cell_rgb = 24'h000000;
        case (w_cell_code)
            2'd0: w_cell_rgb = 24'h000000;
            2'd1: w_cell_rgb = 24'hFF0000;
            2'd2: w_cell_rgb = 24'hFFFF00;
            2'd3: w_cell_rgb = 24'h0000FF;
            default: w_cell_rgb = 24'h000000;
        endcase

        w_pixel_rgb = 24'h000000;
        if (!r_s1_blank_n) begin
            w_pixel_rgb = 24'h000000;
        end else if (!r_s1_in_grid) begin
            w_pixel_rgb = BG_RGB;
        end else if (r_s1_border) begin
            w_pixel_rgb = BORDER_RGB;
        end else begin
            w_pixel_rgb = w_cell_rgb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb     <= '0;
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
            r_blank_n <= 1'b0;
        end else begin
            r_rgb     <= w_pixel_rgb;
            r_hsync   <= r_s1_hsync;
            r_vsync   <= r_s1_vsync;
            r_blank_n <= r_s1_blank_n;
        end
    end

    // -------------------------------------------------------------------------
    // Shadow writes and once-per-frame commit.
    // -------------------------------------------------------------------------
    assign w_wr_ok   = wr_en && ({1'b0, wr_col} < 5'(COLS)) && ({1'b0, wr_row} < 5'(ROWS));
    assign w_vs_fall = r_vsync_prev && !vsync_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the boards are plain flip-flops rather than a RAM macro, so
            // they can take the asynchronous clear along with everything else.
            r_shadow       <= '{default: '0};
            r_live         <= '{default: '0};
            r_vsync_prev   <= 1'b1;
            r_wr_ack       <= 1'b0;
            r_frame_commit <= 1'b0;
        end else begin
            r_vsync_prev   <= vsync_in;
            r_wr_ack       <= w_wr_ok;
            r_frame_commit <= w_vs_fall;
            // NOTE: non-blocking assignments make a same-cycle write and commit
            // copy the pre-write shadow; the new code waits for the next frame.
            if (w_vs_fall) begin
                r_live <= r_shadow;
            end
            if (w_wr_ok) begin
                r_shadow[wr_row][wr_col] <= wr_code;
            end
        end
    end

    assign wr_ack       = r_wr_ack;
    assign frame_commit = r_frame_commit;
    assign hsync_out    = r_hsync;
    assign vsync_out    = r_vsync;
    assign blank_n_out  = r_blank_n;
    assign red          = r_rgb[23:16];
    assign green        = r_rgb[15:8];
    assign blue         = r_rgb[7:0];

endmodule

// File: tb/tb_vga_cell_renderer.sv
// -----------------------------------------------------------------------------
// tb_vga_cell_renderer
//   Scoreboard bench for vga_cell_renderer with default parameters. Each step
//   drives one pixel (plus an optional write), pushes the expected
//   sync/blank/RGB for that pixel, and pops the entry two clocks later when the
//   DUT presents it. wr_ack and frame_commit are checked one clock after their
//   cause. A small board model (shadow + live) supplies the cell colours.
// -----------------------------------------------------------------------------
module tb_vga_cell_renderer;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] x;
    logic [9:0] y;
    logic       hsync_in;
    logic       vsync_in;
    logic       blank_n_in;
    logic       wr_en;
    logic [3:0] wr_col;
    logic [3:0] wr_row;
    logic [1:0] wr_code;
    logic       wr_ack;
    logic       frame_commit;
    logic       hsync_out;
    logic       vsync_out;
    logic       blank_n_out;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;

    typedef struct {
        logic        hs;
        logic        vs;
        logic        bn;
        logic [23:0] rgb;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] m_shadow [0:11][0:15];
    logic [1:0] m_live   [0:11][0:15];
    logic       m_vs_prev;
    int         total = 0;
    int         bad   = 0;

    vga_cell_renderer dut (
        .clk          (clk),
        .rst          (rst),
        .x            (x),
        .y            (y),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .blank_n_in   (blank_n_in),
        .wr_en        (wr_en),
        .wr_col       (wr_col),
        .wr_row       (wr_row),
        .wr_code      (wr_code),
        .wr_ack       (wr_ack),
        .frame_commit (frame_commit),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .blank_n_out  (blank_n_out),
        .red          (red),
        .green        (green),
        .blue         (blue)
    );

    always #5 clk = ~clk;

    // Expected colour from the geometry of a 16x12 grid of 32-pixel cells at (64,48).
    function automatic logic [23:0] exp_rgb(input int px, input int py, input logic bn);
        int cx, cy, lx, ly;
        if (!bn) return 24'h000000;
        if (px < 64 || px >= 576 || py < 48 || py >= 432) return 24'h000040;
        cx = (px - 64) / 32;
        cy = (py - 48) / 32;
        lx = (px - 64) % 32;
        ly = (py - 48) % 32;
        if (lx == 0 || lx == 31 || ly == 0 || ly == 31) return 24'hFFFFFF;
        case (m_live[cy][cx])
            2'd0:    return 24'h000000;
            2'd1:    return 24'hFF0000;
            2'd2:    return 24'hFFFF00;
            default: return 24'h0000FF;
        endcase
    endfunction

    task automatic clear_model();
        m_shadow  = '{default: '0};
        m_live    = '{default: '0};
        m_vs_prev = 1'b1;
        sb.delete();
    endtask

    // One pixel clock of stimulus. Called at posedge+1, returns at posedge+1.
    task automatic step(input int px, input int py, input logic hs, input logic vs,
                        input logic bn, input logic we = 1'b0, input int wc = 0,
                        input int wr = 0, input int code = 0);
        exp_t e;
        logic e_ack;
        logic e_commit;
        x          = 10'(px);
        y          = 10'(py);
        hsync_in   = hs;
        vsync_in   = vs;
        blank_n_in = bn;
        wr_en      = we;
        wr_col     = 4'(wc);
        wr_row     = 4'(wr);
        wr_code    = 2'(code);
        e.hs  = hs;
        e.vs  = vs;
        e.bn  = bn;
        e.rgb = exp_rgb(px, py, bn);
        sb.push_back(e);
        e_ack    = we && (wc < 16) && (wr < 12);
        e_commit = m_vs_prev && !vs;
        @(posedge clk);
        #1;
        // Commit sees the shadow as it was before this cycle's write.
        if (e_commit) m_live = m_shadow;
        if (e_ack) m_shadow[wr][wc] = 2'(code);
        m_vs_prev = vs;
        total++;
        if (wr_ack !== e_ack) begin
            bad++;
            $display("FAIL wr_ack t=%0t: got %b want %b", $time, wr_ack, e_ack);
        end
        total++;
        if (frame_commit !== e_commit) begin
            bad++;
            $display("FAIL frame_commit t=%0t: got %b want %b", $time, frame_commit, e_commit);
        end
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            total++;
            if ({red, green, blue} !== e.rgb) begin
                bad++;
                $display("FAIL rgb t=%0t: got %h want %h", $time, {red, green, blue}, e.rgb);
            end
            total++;
            if ({hsync_out, vsync_out, blank_n_out} !== {e.hs, e.vs, e.bn}) begin
                bad++;
                $display("FAIL sync t=%0t: got hs/vs/bn=%b%b%b want %b%b%b", $time,
                         hsync_out, vsync_out, blank_n_out, e.hs, e.vs, e.bn);
            end
        end
    endtask

    task automatic idle(input int n, input logic vs);
        for (int i = 0; i < n; i++) step(700, 500, 1'b1, vs, 1'b0);
    endtask

    // vsync high, falls, stays low for a while, rises again.
    task automatic do_commit();
        idle(1, 1'b1);
        idle(3, 1'b0);
        idle(1, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if ({red, green, blue, hsync_out, vsync_out, blank_n_out, wr_ack, frame_commit} !==
            {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL %s: got rgb=%h hs=%b vs=%b bn=%b ack=%b fc=%b want rgb=0 hs=1 vs=1 bn=0 ack=0 fc=0",
                     tag, {red, green, blue}, hsync_out, vsync_out, blank_n_out, wr_ack, frame_commit);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            x          = 10'($urandom_range(0, 799));
            y          = 10'($urandom_range(0, 524));
            hsync_in   = 1'($urandom);
            vsync_in   = 1'($urandom);
            blank_n_in = 1'($urandom);
            wr_en      = 1'($urandom);
            wr_col     = 4'($urandom);
            wr_row     = 4'($urandom);
            wr_code    = 2'($urandom);
            @(posedge clk);
            #1;
            check_reset_outputs("reset_hold");
        end
        wr_en      = 1'b0;
        vsync_in   = 1'b1;
        hsync_in   = 1'b1;
        blank_n_in = 1'b0;
        rst        = 1'b0;
        clear_model();
        for (int i = 0; i < 4; i++) step(100, 100, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_pipeline();
        for (int i = 0; i < 3; i++) step(10, 10, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(10, 10, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) step(10, 10, 1'b1, 1'b1, 1'b1);
        step(10, 10, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_commit();
        step(0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 2, 3, 1);
        for (int i = 0; i < 3; i++) step(138, 154, 1'b1, 1'b1, 1'b1);
        do_commit();
        for (int i = 0; i < 3; i++) step(138, 154, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_border_bg();
        step(64, 60, 1'b1, 1'b1, 1'b1);
        step(63, 60, 1'b1, 1'b1, 1'b1);
        step(576, 60, 1'b1, 1'b1, 1'b1);
        step(575, 60, 1'b1, 1'b1, 1'b1);
        step(100, 431, 1'b1, 1'b1, 1'b1);
        step(100, 432, 1'b1, 1'b1, 1'b1);
        step(100, 47, 1'b1, 1'b1, 1'b1);
        step(700, 300, 1'b1, 1'b1, 1'b0);
        step(139, 154, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_oob_write();
        step(0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 15, 12, 2);
        step(0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 15, 15, 3);
        do_commit();
        for (int i = 0; i < 2; i++) step(554, 410, 1'b1, 1'b1, 1'b1);
        step(138, 154, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_collision();
        idle(1, 1'b1);
        step(700, 500, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 3);
        idle(2, 1'b0);
        idle(1, 1'b1);
        for (int i = 0; i < 2; i++) step(74, 58, 1'b1, 1'b1, 1'b1);
        do_commit();
        for (int i = 0; i < 2; i++) step(74, 58, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        step(0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 4, 5, 2);
        step(0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 5, 5, 3);
        step(0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 6, 5, 1);
        step(0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 2, 3, 0);
        do_commit();
        step(202, 218, 1'b1, 1'b1, 1'b1);
        step(234, 218, 1'b1, 1'b1, 1'b1);
        step(266, 218, 1'b1, 1'b1, 1'b1);
        step(138, 154, 1'b1, 1'b1, 1'b1);
        step(74, 58, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_midframe_reset();
        for (int i = 0; i < 3; i++) step(202, 218, 1'b1, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_midframe");
        @(posedge clk);
        #1;
        check_reset_outputs("reset_midframe_hold");
        rst = 1'b0;
        clear_model();
        for (int i = 0; i < 3; i++) step(202, 218, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) step(64, 60, 1'b1, 1'b1, 1'b1);
        idle(2, 1'b1);
    endtask

    initial begin
        rst        = 1'b1;
        x          = '0;
        y          = '0;
        hsync_in   = 1'b1;
        vsync_in   = 1'b1;
        blank_n_in = 1'b0;
        wr_en      = 1'b0;
        wr_col     = '0;
        wr_row     = '0;
        wr_code    = '0;
        clear_model();
        #1;
        test_reset();
        test_pipeline();
        test_commit();
        test_border_bg();
        test_oob_write();
        test_collision();
        test_back_to_back();
        test_midframe_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
